// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline constants: datapath width,
// ALUOp classes, ALUControl codes and the mem/wb control bundle.
package riscv_pkg;

    localparam int XLEN = 64;

    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_BR    = 2'b01;
    localparam logic [1:0] ALUOP_ARITH = 2'b10;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    typedef struct packed {
        logic reg_write;
        logic mem_read;
        logic mem_write;
        logic mem_to_reg;
    } mem_ctrl_t;

endpackage

// File: rtl/alu_ctrl_dec.sv
// ALUOp/funct decoder producing the 4-bit ALUControl code
// and a flag for encodings the ALU does not implement.
module alu_ctrl_dec (
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       alu_src,
    output logic [3:0] alu_control,
    output logic       illegal
);
    import riscv_pkg::*;

    always_comb begin
        alu_control = ALU_ADD;
        illegal     = 1'b0;
        case (alu_op)
            ALUOP_MEM: alu_control = ALU_ADD;
            ALUOP_BR:  alu_control = ALU_SUB;
            ALUOP_ARITH: begin
                case (funct3)
                    // immediate forms never subtract, bit 30 is imm data
                    3'b000: alu_control = (funct7b5 && !alu_src)
                                          ? ALU_SUB : ALU_ADD;
                    3'b111: alu_control = ALU_AND;
                    3'b110: alu_control = ALU_OR;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU control decode and
// EX/MEM, MEM/WB operand forwarding in front of the ALU.
module id_ex_stage #(
    parameter int XLEN    = riscv_pkg::XLEN,
    parameter int RADDR_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [XLEN-1:0]    rs1_data,
    input  logic [XLEN-1:0]    rs2_data,
    input  logic [XLEN-1:0]    imm,
    input  logic [RADDR_W-1:0] rs1_addr,
    input  logic [RADDR_W-1:0] rs2_addr,
    input  logic [RADDR_W-1:0] rd_addr,
    input  logic [1:0]         alu_op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               alu_src,
    input  logic               reg_write,
    input  logic               mem_read,
    input  logic               mem_write,
    input  logic               mem_to_reg,
    input  logic               flush,
    input  logic               exmem_reg_write,
    input  logic [RADDR_W-1:0] exmem_rd,
    input  logic [XLEN-1:0]    exmem_result,
    input  logic               memwb_reg_write,
    input  logic [RADDR_W-1:0] memwb_rd,
    input  logic [XLEN-1:0]    memwb_result,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    x,
    output logic [XLEN-1:0]    y,
    output logic [3:0]         alu_control,
    output logic [XLEN-1:0]    store_data,
    output logic [RADDR_W-1:0] rd_q,
    output logic               reg_write_q,
    output logic               mem_read_q,
    output logic               mem_write_q,
    output logic               mem_to_reg_q,
    output logic               illegal_q
);
    import riscv_pkg::*;

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    rs1_data_q, rs1_data_d;
    logic [XLEN-1:0]    rs2_data_q, rs2_data_d;
    logic [XLEN-1:0]    imm_q, imm_d;
    logic [RADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [RADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [RADDR_W-1:0] rd_d;
    logic               alu_src_q, alu_src_d;
    logic [3:0]         alu_control_q, alu_control_d;
    logic               illegal_d;
    mem_ctrl_t          ctrl_q, ctrl_d;

    logic [3:0]         dec_control;
    logic               dec_illegal;
    logic               capture;

    alu_ctrl_dec u_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_src     (alu_src),
        .alu_control (dec_control),
        .illegal     (dec_illegal)
    );

    assign in_ready = !valid_q || out_ready || flush;
    assign capture  = in_valid && in_ready && !flush;

    always_comb begin
        rs1_data_d    = rs1_data_q;
        rs2_data_d    = rs2_data_q;
        imm_d         = imm_q;
        rs1_addr_d    = rs1_addr_q;
        rs2_addr_d    = rs2_addr_q;
        rd_d          = rd_q;
        alu_src_d     = alu_src_q;
        alu_control_d = alu_control_q;
        illegal_d     = illegal_q;
        ctrl_d        = ctrl_q;
        if (capture) begin
            rs1_data_d    = rs1_data;
            rs2_data_d    = rs2_data;
            imm_d         = imm;
            rs1_addr_d    = rs1_addr;
            rs2_addr_d    = rs2_addr;
            rd_d          = rd_addr;
            alu_src_d     = alu_src;
            alu_control_d = dec_control;
            illegal_d     = dec_illegal;
            ctrl_d        = '{reg_write, mem_read,
                              mem_write, mem_to_reg};
        end
    end

    // flush beats capture; otherwise an accept drains the slot
    always_comb begin
        valid_d = valid_q;
        if (flush)          valid_d = 1'b0;
        else if (capture)   valid_d = 1'b1;
        else if (out_ready) valid_d = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q       <= 1'b0;
            rs1_data_q    <= '0;
            rs2_data_q    <= '0;
            imm_q         <= '0;
            rs1_addr_q    <= '0;
            rs2_addr_q    <= '0;
            rd_q          <= '0;
            alu_src_q     <= 1'b0;
            alu_control_q <= 4'b0000;
            illegal_q     <= 1'b0;
            ctrl_q        <= '0;
        end else begin
            valid_q       <= valid_d;
            rs1_data_q    <= rs1_data_d;
            rs2_data_q    <= rs2_data_d;
            imm_q         <= imm_d;
            rs1_addr_q    <= rs1_addr_d;
            rs2_addr_q    <= rs2_addr_d;
            rd_q          <= rd_d;
            alu_src_q     <= alu_src_d;
            alu_control_q <= alu_control_d;
            illegal_q     <= illegal_d;
            ctrl_q        <= ctrl_d;
        end
    end

    function automatic logic [XLEN-1:0] fwd(
        input logic [RADDR_W-1:0] addr,
        input logic [XLEN-1:0]    regval
    );
        if (exmem_reg_write && exmem_rd != '0 && exmem_rd == addr)
            return exmem_result;
        else if (memwb_reg_write && memwb_rd != '0 && memwb_rd == addr)
            return memwb_result;
        else
            return regval;
    endfunction

    always_comb begin
        x          = fwd(rs1_addr_q, rs1_data_q);
        store_data = fwd(rs2_addr_q, rs2_data_q);
        y          = alu_src_q ? imm_q : store_data;
    end

    assign out_valid    = valid_q;
    assign alu_control  = alu_control_q;
    assign reg_write_q  = ctrl_q.reg_write;
    assign mem_read_q   = ctrl_q.mem_read;
    assign mem_write_q  = ctrl_q.mem_write;
    assign mem_to_reg_q = ctrl_q.mem_to_reg;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline stage directly upstream of the 64-bit ALU. Captures decoded operands and control from the decode stage under a valid/ready handshake, generates the 4-bit ALUControl code, and applies EX/MEM and MEM/WB operand forwarding. Its outputs `x`, `y` and `alu_control` drive the ALU ports of the same names. Memory/writeback control passes through to the next stage.

## Interface
Parameters:
- `XLEN`, 64, datapath width.
- `RADDR_W`, 5, register address width.

Ports (clock and reset first):
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  decode beat valid.
- `in_ready`  out  1  stage can accept a beat.
- `rs1_data`, `rs2_data`, `imm`  in  XLEN  register-file operands and immediate.
- `rs1_addr`, `rs2_addr`, `rd_addr`  in  RADDR_W  source and destination registers.
- `alu_op`  in  2  00 = mem add, 01 = branch sub, 10 = arith, 11 = reserved.
- `funct3`  in  3  instruction funct3.
- `funct7b5`  in  1  instruction bit 30.
- `alu_src`  in  1  1 selects `imm` for `y`.
- `reg_write`, `mem_read`, `mem_write`, `mem_to_reg`  in  1  pass-through control.
- `flush`  in  1  squash the held beat.
- `exmem_reg_write`  in  1, `exmem_rd`  in  RADDR_W, `exmem_result`  in  XLEN  EX/MEM forward source.
- `memwb_reg_write`  in  1, `memwb_rd`  in  RADDR_W, `memwb_result`  in  XLEN  MEM/WB forward source.
- `out_valid`  out  1  held beat valid.
- `out_ready`  in  1  downstream accepts.
- `x`, `y`  out  XLEN  ALU operands.
- `alu_control`  out  4  ALU opcode.
- `store_data`  out  XLEN  forwarded rs2 value.
- `rd_q`  out  RADDR_W, plus `reg_write_q`, `mem_read_q`, `mem_write_q`, `mem_to_reg_q`  out  1  registered control.
- `illegal_q`  out  1  unsupported ALU encoding.

## Operation
- **Single register slot.** `in_ready = !out_valid || out_ready || flush`. A beat is captured on the edge when `in_valid && in_ready && !flush`.
- **`out_valid` next-state:**
  - 0 if `flush`.
  - Otherwise 1 if capture.
  - Otherwise 0 if `out_ready`.
  - Otherwise hold.
- **Flush.** Has priority over capture. An incoming beat in a flush cycle is consumed and discarded.
- **Held slot.** While `out_valid && !out_ready`, all registered fields hold.
- **Decode (registered at capture):**
  - `alu_op` 00 → 0010.
  - `alu_op` 01 → 0110.
  - `alu_op` 10, by `funct3`:
    - 000 → 0110 if `funct7b5 && !alu_src`, else 0010.
    - 111 → 0000.
    - 110 → 0001.
    - Any other `funct3` → 0010 with `illegal_q` = 1.
  - `alu_op` 11 → 0010 with `illegal_q` = 1.
- **Forwarding.** Combinational on the registered addresses and data, applied separately to rs1 and rs2.
  - Priority: EX/MEM first, then MEM/WB, then the registered register-file value.
  - A source matches only if its `*_reg_write` = 1, its `*_rd` ≠ 0, and its `*_rd` equals the register address.
- **Outputs:**
  - `x` = forwarded rs1.
  - `store_data` = forwarded rs2.
  - `y` = `alu_src` ? registered `imm` : forwarded rs2.
- **Width.** All data paths are XLEN bits; there is no extension or truncation.

## Timing
- **Reset.** `out_valid` = 0, all registered data/address/control = 0, `alu_control` = 0000, `illegal_q` = 0. `x`, `y`, `store_data` therefore read 0, because address 0 is never forwarded.
- **Reset mid-operation.** Any held beat is lost; `in_ready` = 1 the cycle after reset deasserts.
- **Latency.** 1 cycle from capture to `out_valid`.
- **Throughput.** 1 beat/cycle when `out_ready` stays high.
- **Same-cycle accept.** Accepting downstream and capturing upstream in the same cycle is allowed; it replaces the slot with no bubble.
- **Forwarding path.** Forwarding inputs are sampled combinationally every cycle. While stalled, `x`/`y` track the current forward sources.

## Structure
- Shared package `riscv_pkg`:
  - ALUControl constants `ALU_ADD`=0010, `ALU_SUB`=0110, `ALU_AND`=0000, `ALU_OR`=0001.
  - ALUOp constants `ALUOP_MEM`, `ALUOP_BR`, `ALUOP_ARITH`.
  - `XLEN` default.
- One combinational sub-module, `alu_ctrl_dec`: (`alu_op`, `funct3`, `funct7b5`, `alu_src`) → (`alu_control`, `illegal`).
- Handshake, registers and forwarding muxes live in `id_ex_stage`.

## Test plan
- **Reset:** assert `rst` mid-beat → `out_valid`=0, `alu_control`=0000, `x`=`y`=0, `in_ready`=1.
- **R-type sub:** `alu_op`=10, `funct3`=000, `funct7b5`=1, `alu_src`=0, rs1=10, rs2=3 → next cycle `alu_control`=0110, `x`=10, `y`=3. Same with `alu_src`=1, `imm`=5 → 0010, `y`=5.
- **Forwarding:** `rs1_addr`=5, `exmem_rd`=5, `exmem_result`=0xAA, `memwb_rd`=5, `memwb_result`=0xBB → `x`=0xAA. Drop `exmem_reg_write` → 0xBB. With `rs1_addr`=0 → `x` = registered value.
- **Backpressure:** `out_ready`=0 for 3 cycles with `in_valid`=1 → `in_ready`=0, outputs stable, no beat lost. Then `out_ready`=1 → next beat captured the same edge.
- **Flush:** `flush`=1 with `in_valid`=1 → `out_valid`=0 next cycle and the incoming beat is dropped.
- **Illegal:** `alu_op`=10, `funct3`=001 → `alu_control`=0010, `illegal_q`=1. `alu_op`=11 → same.
